// File: rtl/outport_arbiter.sv
// Output-port arbiter: round-robin packet lock over four input FIFOs with credit-based flow control.
// Optional 16-bit output flit counter enabled by defining OUTARB_FLIT_CNT_EN.
module outport_arbiter #(
   parameter int unsigned NUM_BITS = 8,
   parameter int unsigned CREDITS  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            in_empty,
   input  logic [4*NUM_BITS-1:0] in_data,
   output logic [3:0]            in_rd_en,
   output logic [NUM_BITS-1:0]   out_flit,
   output logic                  out_valid,
   input  logic                  credit_in,
   output logic [3:0]            grant,
   output logic                  credit_err
`ifdef OUTARB_FLIT_CNT_EN
   ,
   output logic [15:0]           flit_cnt
`endif
);

   localparam int unsigned NPORT = 4;
   localparam int unsigned PW    = 2;
   localparam int unsigned CW    = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

   typedef enum logic {S_IDLE, S_LOCK} state_t;

   state_t              state, state_d;
   logic [PW-1:0]       gport, gport_d;
   logic [PW-1:0]       rr_ptr, rr_ptr_d;
   logic [PW-1:0]       pend_port, pend_port_d;
   logic                pend_valid, pend_valid_d;
   logic [CW-1:0]       credits, credits_d;
   logic [NUM_BITS-1:0] out_flit_d;
   logic                out_valid_d;
   logic                credit_err_d;
   logic [3:0]          grant_d;
   logic [3:0]          rd_en_c;
   logic                rd_issue;
   logic [NUM_BITS-1:0] in_word [NPORT];
   logic [NUM_BITS-1:0] ret_flit;
   logic                ret_tail;
   logic                arb_hit;
   logic [PW-1:0]       arb_port;

   always_comb begin
      for (int i = 0; i < NPORT; i++) begin
         in_word[i] = in_data[i*NUM_BITS +: NUM_BITS];
      end
   end

   // Flit returning from the read issued last cycle; MSB set means tail or single.
   assign ret_flit = in_word[pend_port];
   assign ret_tail = pend_valid && ret_flit[NUM_BITS-1];

   // Round-robin: first non-empty port strictly after rr_ptr, rr_ptr itself last.
   always_comb begin
      arb_hit  = 1'b0;
      arb_port = rr_ptr;
      for (int k = 1; k <= NPORT; k++) begin
         if (!arb_hit && !in_empty[rr_ptr + PW'(k)]) begin
            arb_hit  = 1'b1;
            arb_port = rr_ptr + PW'(k);
         end
      end
   end

   always_comb begin
      state_d      = state;
      gport_d      = gport;
      rr_ptr_d     = rr_ptr;
      pend_valid_d = 1'b0;
      pend_port_d  = pend_port;
      credits_d    = credits;
      out_flit_d   = out_flit;
      out_valid_d  = 1'b0;
      credit_err_d = credit_err;
      grant_d      = grant;
      rd_en_c      = '0;
      rd_issue     = 1'b0;

      if (pend_valid) begin
         out_flit_d  = ret_flit;
         out_valid_d = 1'b1;
      end

      // A returning tail blocks any read this cycle, giving one bubble before re-arbitration.
      case (state)
         S_IDLE: begin
            if (!ret_tail && arb_hit && credits != '0) begin
               rd_en_c[arb_port] = 1'b1;
               rd_issue          = 1'b1;
               pend_port_d       = arb_port;
               gport_d           = arb_port;
               grant_d           = 4'b0001 << arb_port;
               state_d           = S_LOCK;
            end
         end
         S_LOCK: begin
            if (!ret_tail && !in_empty[gport] && credits != '0) begin
               rd_en_c[gport] = 1'b1;
               rd_issue       = 1'b1;
               pend_port_d    = gport;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (ret_tail) begin
         state_d  = S_IDLE;
         grant_d  = '0;
         rr_ptr_d = pend_port;
      end

      if (rd_issue) begin
         pend_valid_d = 1'b1;
      end

      case ({rd_issue, credit_in})
         2'b10: credits_d = credits - CW'(1);
         2'b01: begin
            if (credits == CRED_MAX) begin
               credit_err_d = 1'b1;
            end else begin
               credits_d = credits + CW'(1);
            end
         end
         default: credits_d = credits;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         gport      <= '0;
         rr_ptr     <= PW'(NPORT - 1);
         pend_port  <= '0;
         pend_valid <= 1'b0;
         credits    <= CRED_MAX;
         out_flit   <= '0;
         out_valid  <= 1'b0;
         credit_err <= 1'b0;
         grant      <= '0;
      end else begin
         state      <= state_d;
         gport      <= gport_d;
         rr_ptr     <= rr_ptr_d;
         pend_port  <= pend_port_d;
         pend_valid <= pend_valid_d;
         credits    <= credits_d;
         out_flit   <= out_flit_d;
         out_valid  <= out_valid_d;
         credit_err <= credit_err_d;
         grant      <= grant_d;
      end
   end

   // Read enables must drop the instant reset asserts, not at the next edge.
   assign in_rd_en = rd_en_c & {4{rst_n}};

`ifdef OUTARB_FLIT_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flit_cnt <= '0;
      end else if (out_valid) begin
         flit_cnt <= flit_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_outport_arbiter.sv
// Scoreboard bench for outport_arbiter: FIFO models feed directed packets, a monitor checks every output flit.
module tb_outport_arbiter;

   localparam int unsigned NB = 8;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 credit_in = 1'b0;
   logic [3:0]           in_empty = 4'hF;
   logic [3:0][NB-1:0]   rdata = '0;
   logic [4*NB-1:0]      in_data;
   logic [3:0]           in_rd_en;
   logic [3:0]           grant;
   logic [NB-1:0]        out_flit;
   logic                 out_valid;
   logic                 credit_err;
`ifdef OUTARB_FLIT_CNT_EN
   logic [15:0]          flit_cnt;
`endif

   logic [NB-1:0] fq0[$], fq1[$], fq2[$], fq3[$];
   logic [NB-1:0] exp_q[$];
   int checks = 0;
   int failures = 0;
   int rd_count = 0;

   assign in_data = rdata;

   always #5 clk = ~clk;

   outport_arbiter #(.NUM_BITS(NB), .CREDITS(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_empty   (in_empty),
      .in_data    (in_data),
      .in_rd_en   (in_rd_en),
      .out_flit   (out_flit),
      .out_valid  (out_valid),
      .credit_in  (credit_in),
      .grant      (grant),
      .credit_err (credit_err)
`ifdef OUTARB_FLIT_CNT_EN
      ,
      .flit_cnt   (flit_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Upstream FIFOs: data appears the cycle after rd_en, empty flags update on the edge.
   always @(posedge clk) begin
      if (in_rd_en[0] && fq0.size() > 0) rdata[0] <= fq0.pop_front();
      if (in_rd_en[1] && fq1.size() > 0) rdata[1] <= fq1.pop_front();
      if (in_rd_en[2] && fq2.size() > 0) rdata[2] <= fq2.pop_front();
      if (in_rd_en[3] && fq3.size() > 0) rdata[3] <= fq3.pop_front();
      in_empty <= {fq3.size() == 0, fq2.size() == 0, fq1.size() == 0, fq0.size() == 0};
   end

   // Monitor: scoreboard pop on every valid flit plus read-enable legality.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_rd_en != 4'b0000) rd_count++;
         check("rd_onehot", 32'($countones(in_rd_en) <= 1), 32'd1);
         check("rd_on_empty", 32'(in_rd_en & in_empty), 32'd0);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_flit: got 0x%0h expected no output", out_flit);
            end else begin
               check("flit", 32'(out_flit), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic send(input int p, input logic [NB-1:0] f);
      case (p)
         0: fq0.push_back(f);
         1: fq1.push_back(f);
         2: fq2.push_back(f);
         default: fq3.push_back(f);
      endcase
      exp_q.push_back(f);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_credit();
      credit_in = 1'b1;
      @(negedge clk);
      credit_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic cyc(input string tag, input logic [3:0] rd, input logic v, input logic [3:0] g);
      @(negedge clk);
      #1;
      check({tag, "_rd"}, 32'(in_rd_en), 32'(rd));
      check({tag, "_vld"}, 32'(out_valid), 32'(v));
      check({tag, "_gnt"}, 32'(grant), 32'(g));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      credit_in = 1'b0;
      fq0.delete(); fq1.delete(); fq2.delete(); fq3.delete();
      exp_q.delete();
      step(3);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      step(2);
      #1;
      check("rst_vld", 32'(out_valid), 32'd0);
      check("rst_flit", 32'(out_flit), 32'd0);
      check("rst_gnt", 32'(grant), 32'd0);
      check("rst_rd", 32'(in_rd_en), 32'd0);
      check("rst_err", 32'(credit_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_credits", 32'(dut.credits), 32'd8);
      check("rst_rr", 32'(dut.rr_ptr), 32'd3);
      step(2);

      // Three-flit packet on port 1
      send(1, 8'h41); send(1, 8'h05); send(1, 8'h86);
      cyc("t1c1", 4'b0010, 1'b0, 4'b0000);
      cyc("t1c2", 4'b0010, 1'b0, 4'b0010);
      cyc("t1c3", 4'b0010, 1'b1, 4'b0010);
      cyc("t1c4", 4'b0000, 1'b1, 4'b0010);
      cyc("t1c5", 4'b0000, 1'b1, 4'b0000);
      cyc("t1c6", 4'b0000, 1'b0, 4'b0000);
      check("t1_credits", 32'(dut.credits), 32'd5);
      repeat (3) pulse_credit();
      check("t1_restore", 32'(dut.credits), 32'd8);

      // Two single flits from reset priority: port 0, bubble, port 2
      do_reset();
      step(1);
      send(0, 8'hC1); send(2, 8'hC2);
      cyc("t2c1", 4'b0001, 1'b0, 4'b0000);
      cyc("t2c2", 4'b0000, 1'b0, 4'b0001);
      cyc("t2c3", 4'b0100, 1'b1, 4'b0000);
      cyc("t2c4", 4'b0000, 1'b0, 4'b0100);
      cyc("t2c5", 4'b0000, 1'b1, 4'b0000);
      check("t2_rr", 32'(dut.rr_ptr), 32'd2);
      repeat (2) pulse_credit();
      check("t2_restore", 32'(dut.credits), 32'd8);

      // Ten-flit packet on port 3 exhausts credits after eight reads
      rd_count = 0;
      send(3, 8'h43);
      for (int i = 0; i < 8; i++) send(3, 8'(8'h10 + i));
      send(3, 8'h83);
      step(14);
      #1;
      check("t3_reads", 32'(rd_count), 32'd8);
      check("t3_stall_rd", 32'(in_rd_en), 32'd0);
      check("t3_credits0", 32'(dut.credits), 32'd0);
      check("t3_gnt", 32'(grant), 32'b1000);
      check("t3_inflight_done", 32'(exp_q.size()), 32'd2);
      rd_count = 0;
      pulse_credit();
      step(5);
      #1;
      check("t3_one_read", 32'(rd_count), 32'd1);
      check("t3_one_out", 32'(exp_q.size()), 32'd1);
      check("t3_credits_after", 32'(dut.credits), 32'd0);
      repeat (9) pulse_credit();
      step(4);
      #1;
      check("t3_credits8", 32'(dut.credits), 32'd8);
      check("t3_release", 32'(grant), 32'd0);
      check("t3_drained", 32'(exp_q.size()), 32'd0);
      check("t3_no_err", 32'(credit_err), 32'd0);

      // Credit return coincident with a read, then overflow
      send(0, 8'h40); send(0, 8'h20); send(0, 8'h80);
      cyc("t4c1", 4'b0001, 1'b0, 4'b0000);
      credit_in = 1'b1;
      cyc("t4c2", 4'b0001, 1'b0, 4'b0001);
      credit_in = 1'b0;
      check("t4_same_cycle", 32'(dut.credits), 32'd8);
      step(6);
      check("t4_credits6", 32'(dut.credits), 32'd6);
      repeat (2) pulse_credit();
      check("t4_credits8", 32'(dut.credits), 32'd8);
      pulse_credit();
      check("t4_err_set", 32'(credit_err), 32'd1);
      check("t4_ovf_ignored", 32'(dut.credits), 32'd8);
      step(5);
      check("t4_err_sticky", 32'(credit_err), 32'd1);

      // Reset asserted while a body flit is on the output
      send(1, 8'h51); send(1, 8'h22); send(1, 8'h23); send(1, 8'h91);
      step(4);
      #1;
      check("t5_body_vld", 32'(out_valid), 32'd1);
      check("t5_body_flit", 32'(out_flit), 32'h22);
      check("t5_rd_before", 32'(in_rd_en), 32'b0010);
      rst_n = 1'b0;
      #1;
      check("t5_vld0", 32'(out_valid), 32'd0);
      check("t5_flit0", 32'(out_flit), 32'd0);
      check("t5_gnt0", 32'(grant), 32'd0);
      check("t5_rd0", 32'(in_rd_en), 32'd0);
      check("t5_err0", 32'(credit_err), 32'd0);
      fq0.delete(); fq1.delete(); fq2.delete(); fq3.delete();
      exp_q.delete();
      step(2);
      rst_n = 1'b1;
      #1;
      check("t5_credits8", 32'(dut.credits), 32'd8);
      step(4);
      #1;
      check("t5_quiet_vld", 32'(out_valid), 32'd0);
      check("t5_quiet_credits", 32'(dut.credits), 32'd8);

      // Five-flit packet on port 2
      send(2, 8'h62); send(2, 8'h31); send(2, 8'h32); send(2, 8'h33); send(2, 8'hA2);
      step(12);
      #1;
      check("t6_drained", 32'(exp_q.size()), 32'd0);
      check("t6_gnt", 32'(grant), 32'd0);
`ifdef OUTARB_FLIT_CNT_EN
      check("t6_flit_cnt", 32'(flit_cnt), 32'd5);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/outport_arbiter.md
OUTPORT_ARBITER -- requirements
Module: outport_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 8: flit width, equal to the width of the upstream input FIFO data.
REQ-002 The block SHALL have parameter CREDITS, default 8: initial credit count, equal to the downstream buffer DEPTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_empty, input, 4 bits: empty flags of the four input FIFOs.
REQ-006 The block SHALL have port in_data, input, 4*NUM_BITS bits: FIFO read data; port i occupies bits [i*NUM_BITS +: NUM_BITS].
REQ-007 The block SHALL have port in_rd_en, output, 4 bits: per-FIFO read enables; data returns one cycle later.
REQ-008 The block SHALL have port out_flit, output, NUM_BITS bits: registered flit toward the downstream buffer.
REQ-009 The block SHALL have port out_valid, output, 1 bit: registered qualifier for out_flit, used as downstream wr_en.
REQ-010 The block SHALL have port credit_in, input, 1 bit: one-cycle pulse meaning one downstream slot was freed.
REQ-011 The block SHALL have port grant, output, 4 bits: one-hot locked input port; all zero when idle.
REQ-012 The block SHALL have port credit_err, output, 1 bit: sticky flag set on a credit overflow.

Function
REQ-013 Flit type SHALL be flit[NUM_BITS-1:NUM_BITS-2]: 01 head, 00 body, 10 tail, 11 single (head+tail).
REQ-014 The block SHALL run two states: IDLE (no lock) and LOCK (packet in progress on grant port g).
REQ-015 In IDLE, when any in_empty[i]==0 and credits>0, the block SHALL pick the first non-empty port after rr_ptr (round-robin), assert in_rd_en for that port in the same cycle, set grant, and enter LOCK.
REQ-016 In LOCK, in_rd_en[g] SHALL be asserted when in_empty[g]==0 and credits>0 and no returning tail/single flit is present this cycle; the other in_rd_en bits SHALL be 0.
REQ-017 At most one in_rd_en bit SHALL be high per cycle, and never for an empty port.
REQ-018 A read issued in cycle N SHALL set pend_valid in N+1; in N+1, in_data[g] SHALL be registered so that out_flit/out_valid=1 appear in cycle N+2 (2-cycle latency from rd_en).
REQ-019 When the returned flit is tail or single, the block SHALL clear grant, set rr_ptr=g, and return to IDLE at the next edge; no new arbitration SHALL occur in that cycle (one bubble).
REQ-020 The credit counter (width clog2(CREDITS+1)) SHALL decrement on each issued in_rd_en and increment on each credit_in pulse; when both occur in the same cycle it SHALL be unchanged.
REQ-021 A credit_in pulse with the counter at CREDITS and no read issued SHALL be ignored and SHALL set credit_err.
REQ-022 With credits==0, no read SHALL be issued; flits already in flight SHALL still complete.
REQ-023 A body or tail flit returned while no packet is open SHALL be forwarded unchanged; a tail SHALL still release the lock.
REQ-024 out_valid SHALL be 0 in every cycle not carrying a returned flit.

Reset
REQ-025 While rst_n==0, the block SHALL asynchronously force in_rd_en=0, out_flit=0, out_valid=0, grant=0, credit_err=0, pend_valid=0, state=IDLE, credits=CREDITS, and rr_ptr=3 (port 0 highest priority first).
REQ-026 Reset asserted mid-packet SHALL discard the in-flight flit and the lock with no partial output.

Configuration
REQ-027 When OUTARB_FLIT_CNT_EN is defined, the block SHALL add output flit_cnt[15:0], reset to 0, incremented on every out_valid and wrapping 0xFFFF->0.
REQ-028 When OUTARB_FLIT_CNT_EN is undefined, flit_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL check: reset released, port 1 holds head 0x41, body 0x05, tail 0x86 -> rd_en[1] on 3 consecutive cycles, out_valid 3 cycles starting 2 cycles later, grant=0010 then 0000.
REQ-030 The bench SHALL check: ports 0 and 2 each hold a single flit 0xC1/0xC2 -> port 0 is served first, then port 2 after one bubble, rr_ptr=2.
REQ-031 The bench SHALL check: CREDITS=8, no credit_in, 10-flit packet on port 3 -> exactly 8 reads, stall; one credit_in pulse -> exactly one more read.
REQ-032 The bench SHALL check: credit_in pulsed in the same cycle as a read -> counter unchanged; credit_in at 8 with no read -> credit_err=1 and sticky.
REQ-033 The bench SHALL check: rst_n dropped during a body flit -> all outputs 0 immediately and credits=8 after release.
REQ-034 The bench SHALL check: with OUTARB_FLIT_CNT_EN defined, 5 flits sent -> flit_cnt=5.
